// File: rtl/ipu_prog_loader.sv
// ipu_prog_loader: framed byte stream -> little-endian 32-bit words on the IPU memory write port.
// Optional trailing XOR checksum byte when IPU_LOADER_CKSUM_EN is defined.
module ipu_prog_loader #(
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {
    S_HDR_LO, S_HDR_HI, S_DATA, S_DONE, S_ERR
`ifdef IPU_LOADER_CKSUM_EN
    , S_CKSUM
`endif
  } state_t;
  state_t              r_state;
  logic [7:0]          r_cnt_lo;
  logic [ADDR_W:0]     r_n;
  logic [ADDR_W:0]     r_words;
  logic [1:0]          r_idx;
  logic [31:0]         r_asm;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_hold;
  logic                r_load_done;
  logic                r_load_err;
  logic [15:0]         w_n;
  logic                w_last;
  assign w_n          = {in_data, r_cnt_lo};
  assign w_last       = (r_words + 1'b1) == r_n;
  assign in_ready     = reset && (r_state != S_DONE) && (r_state != S_ERR);
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign load_done    = r_load_done;
  assign load_err     = r_load_err;
  assign words_loaded = r_words;
`ifdef IPU_LOADER_CKSUM_EN
  logic [7:0] r_ck;
  // running XOR of header and payload bytes, restarted by each new header
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_ck <= '0;
    else if (r_state == S_HDR_LO && in_valid) r_ck <= in_data;
    else if ((r_state == S_HDR_HI || r_state == S_DATA) && in_valid) r_ck <= r_ck ^ in_data;
`endif
  // frame FSM with registered memory strobe and status outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state     <= S_HDR_LO;
      r_cnt_lo    <= '0;
      r_n         <= '0;
      r_words     <= '0;
      r_idx       <= '0;
      r_asm       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= ADDR_W'(BASE_ADDR);
      r_mem_wdata <= '0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        S_HDR_LO: if (in_valid) begin
          r_cnt_lo <= in_data;
          r_state  <= S_HDR_HI;
        end
        S_HDR_HI: if (in_valid) begin
          if (w_n == '0) begin
`ifdef IPU_LOADER_CKSUM_EN
            r_state <= S_CKSUM;
`else
            r_state     <= S_DONE;
            r_load_done <= 1'b1;
            r_cpu_hold  <= 1'b0;
`endif
          end else if (32'(w_n) > MAX_WORDS) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end else begin
            r_n     <= w_n[ADDR_W:0];
            r_state <= S_DATA;
          end
        end
        S_DATA: if (in_valid) begin
          r_asm[8*r_idx +: 8] <= in_data;
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_mem_we    <= 1'b1;
            r_mem_wdata <= {in_data, r_asm[23:0]};
            r_mem_addr  <= ADDR_W'(BASE_ADDR) + r_words[ADDR_W-1:0];
            r_words     <= r_words + 1'b1;
            if (w_last) begin
`ifdef IPU_LOADER_CKSUM_EN
              r_state <= S_CKSUM;
`else
              r_state     <= S_DONE;
              r_load_done <= 1'b1;
              r_cpu_hold  <= 1'b0;
`endif
            end
          end
        end
`ifdef IPU_LOADER_CKSUM_EN
        S_CKSUM: if (in_valid) begin
          r_state     <= (in_data == r_ck) ? S_DONE : S_ERR;
          r_load_done <= in_data == r_ck;
          r_cpu_hold  <= in_data != r_ck;
          r_load_err  <= in_data != r_ck;
        end
`endif
        S_DONE, S_ERR: if (load_start) begin
          r_state     <= S_HDR_LO;
          r_cpu_hold  <= 1'b1;
          r_load_done <= 1'b0;
          r_load_err  <= 1'b0;
          r_words     <= '0;
          r_idx       <= '0;
          r_n         <= '0;
          r_asm       <= '0;
        end
        default: r_state <= S_HDR_LO;
      endcase
    end
endmodule
